// File: rtl/robot_sensor_conditioner.sv
// Sensor input stage: per-channel synchroniser, debounce FSM, edge pulses and
// a saturating count of rejected (glitch) transitions.
module robot_sensor_conditioner #(
  parameter int N_CH        = 5,
  parameter int SYNC_STAGES = 2,
  parameter int DB_CYCLES   = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] raw_in,
  input  logic            enable,
  input  logic            glitch_clr,
  output logic [N_CH-1:0] x_out,
  output logic [N_CH-1:0] x_rise,
  output logic [N_CH-1:0] x_fall,
  output logic [N_CH-1:0] pending,
  output logic [7:0]      glitch_cnt
);

  typedef enum logic {IDLE = 1'b0, PEND = 1'b1} state_t;

  localparam logic [3:0] DB_LAST = 4'(DB_CYCLES - 1);

  logic [SYNC_STAGES-1:0][N_CH-1:0] sync_q, sync_d;
  logic [N_CH-1:0] s;
  logic [N_CH-1:0] glitch;
  logic [7:0]      glitch_cnt_q, glitch_cnt_d;
  logic [8:0]      glitch_sum;
  logic [8:0]      glitch_total;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], raw_in};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign s = sync_q[SYNC_STAGES-1];

  for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       x_q, x_d;
    logic       rise_q, rise_d;
    logic       fall_q, fall_d;
    logic       accept;
    logic       glitch_ev;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        state_q <= IDLE;
        cnt_q   <= 4'd0;
        x_q     <= 1'b0;
        rise_q  <= 1'b0;
        fall_q  <= 1'b0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        x_q     <= x_d;
        rise_q  <= rise_d;
        fall_q  <= fall_d;
      end
    end

    // Disable parks the channel so a re-enable always starts a fresh count.
    always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      accept    = 1'b0;
      glitch_ev = 1'b0;
      if (!enable) begin
        state_d = IDLE;
        cnt_d   = 4'd0;
      end else begin
        case (state_q)
          IDLE: begin
            if (s[gi] != x_q) begin
              if (DB_CYCLES == 1) begin
                accept = 1'b1;
              end else begin
                state_d = PEND;
                cnt_d   = 4'd1;
              end
            end
          end
          default: begin
            if (s[gi] == x_q) begin
              state_d   = IDLE;
              cnt_d     = 4'd0;
              glitch_ev = 1'b1;
            end else if (cnt_q == DB_LAST) begin
              accept  = 1'b1;
              state_d = IDLE;
              cnt_d   = 4'd0;
            end else begin
              cnt_d = cnt_q + 4'd1;
            end
          end
        endcase
      end
    end

    always_comb begin
      x_d    = x_q;
      rise_d = 1'b0;
      fall_d = 1'b0;
      if (accept) begin
        x_d    = s[gi];
        rise_d = s[gi];
        fall_d = ~s[gi];
      end
    end

    assign glitch[gi]  = glitch_ev;
    assign x_out[gi]   = x_q;
    assign x_rise[gi]  = rise_q;
    assign x_fall[gi]  = fall_q;
    assign pending[gi] = (state_q == PEND);
  end

  // Clear takes priority over any glitch events landing on the same edge.
  always_comb begin
    glitch_sum = 9'd0;
    for (int i = 0; i < N_CH; i++) begin
      glitch_sum = glitch_sum + 9'(glitch[i]);
    end
    glitch_total = {1'b0, glitch_cnt_q} + glitch_sum;
    if (glitch_clr) begin
      glitch_cnt_d = 8'd0;
    end else if (glitch_total > 9'd255) begin
      glitch_cnt_d = 8'hFF;
    end else begin
      glitch_cnt_d = glitch_total[7:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      glitch_cnt_q <= 8'd0;
    end else begin
      glitch_cnt_q <= glitch_cnt_d;
    end
  end

  assign glitch_cnt = glitch_cnt_q;

endmodule

// File: tb/tb_robot_sensor_conditioner.sv
// Directed bench: cycle-by-cycle vector table for debounce, glitch and edge
// behaviour, followed by hand-written saturation, enable and reset sequences.
module tb_robot_sensor_conditioner;

  logic       clk;
  logic       rst;
  logic [4:0] raw_in;
  logic       enable;
  logic       glitch_clr;
  logic [4:0] x_out;
  logic [4:0] x_rise;
  logic [4:0] x_fall;
  logic [4:0] pending;
  logic [7:0] glitch_cnt;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [4:0] raw;
    logic       en;
    logic       clr;
    logic [4:0] ex;
    logic [4:0] er;
    logic [4:0] ef;
    logic [4:0] ep;
    logic [7:0] eg;
  } vec_t;

  vec_t vecs [24];

  robot_sensor_conditioner dut (
    .clk        (clk),
    .rst        (rst),
    .raw_in     (raw_in),
    .enable     (enable),
    .glitch_clr (glitch_clr),
    .x_out      (x_out),
    .x_rise     (x_rise),
    .x_fall     (x_fall),
    .pending    (pending),
    .glitch_cnt (glitch_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, required finish before 1ms");
    $fatal(1);
  end

  task automatic check(input string name, input logic [4:0] ex, input logic [4:0] er,
                       input logic [4:0] ef, input logic [4:0] ep, input logic [7:0] eg);
    checks++;
    if (x_out !== ex || x_rise !== er || x_fall !== ef || pending !== ep || glitch_cnt !== eg) begin
      failures++;
      $display("FAIL %s: got x=%h rise=%h fall=%h pend=%h gcnt=%0d, required x=%h rise=%h fall=%h pend=%h gcnt=%0d",
               name, x_out, x_rise, x_fall, pending, glitch_cnt, ex, er, ef, ep, eg);
    end else begin
      $display("ok   %s: x=%h rise=%h fall=%h pend=%h gcnt=%0d",
               name, x_out, x_rise, x_fall, pending, glitch_cnt);
    end
  endtask

  // Inputs are driven just after a falling edge; outputs are read on the next one.
  task automatic cyc(input logic [4:0] r, input logic e, input logic c);
    raw_in     = r;
    enable     = e;
    glitch_clr = c;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    // raw, en, clr -> x, rise, fall, pend, gcnt (state after that rising edge)
    vecs[0]  = '{5'h08, 1'b1, 1'b0, 5'h00, 5'h00, 5'h00, 5'h00, 8'd0};
    vecs[1]  = '{5'h08, 1'b1, 1'b0, 5'h00, 5'h00, 5'h00, 5'h00, 8'd0};
    vecs[2]  = '{5'h08, 1'b1, 1'b0, 5'h00, 5'h00, 5'h00, 5'h08, 8'd0};
    vecs[3]  = '{5'h08, 1'b1, 1'b0, 5'h00, 5'h00, 5'h00, 5'h08, 8'd0};
    vecs[4]  = '{5'h08, 1'b1, 1'b0, 5'h00, 5'h00, 5'h00, 5'h08, 8'd0};
    vecs[5]  = '{5'h08, 1'b1, 1'b0, 5'h08, 5'h08, 5'h00, 5'h00, 8'd0};
    vecs[6]  = '{5'h08, 1'b1, 1'b0, 5'h08, 5'h00, 5'h00, 5'h00, 8'd0};
    vecs[7]  = '{5'h09, 1'b1, 1'b0, 5'h08, 5'h00, 5'h00, 5'h00, 8'd0};
    vecs[8]  = '{5'h09, 1'b1, 1'b0, 5'h08, 5'h00, 5'h00, 5'h00, 8'd0};
    vecs[9]  = '{5'h08, 1'b1, 1'b0, 5'h08, 5'h00, 5'h00, 5'h01, 8'd0};
    vecs[10] = '{5'h08, 1'b1, 1'b0, 5'h08, 5'h00, 5'h00, 5'h01, 8'd0};
    vecs[11] = '{5'h08, 1'b1, 1'b0, 5'h08, 5'h00, 5'h00, 5'h00, 8'd1};
    vecs[12] = '{5'h0E, 1'b1, 1'b0, 5'h08, 5'h00, 5'h00, 5'h00, 8'd1};
    vecs[13] = '{5'h0E, 1'b1, 1'b0, 5'h08, 5'h00, 5'h00, 5'h00, 8'd1};
    vecs[14] = '{5'h08, 1'b1, 1'b0, 5'h08, 5'h00, 5'h00, 5'h06, 8'd1};
    vecs[15] = '{5'h08, 1'b1, 1'b0, 5'h08, 5'h00, 5'h00, 5'h06, 8'd1};
    vecs[16] = '{5'h08, 1'b1, 1'b0, 5'h08, 5'h00, 5'h00, 5'h00, 8'd3};
    vecs[17] = '{5'h10, 1'b1, 1'b0, 5'h08, 5'h00, 5'h00, 5'h00, 8'd3};
    vecs[18] = '{5'h10, 1'b1, 1'b0, 5'h08, 5'h00, 5'h00, 5'h00, 8'd3};
    vecs[19] = '{5'h10, 1'b1, 1'b0, 5'h08, 5'h00, 5'h00, 5'h18, 8'd3};
    vecs[20] = '{5'h10, 1'b1, 1'b0, 5'h08, 5'h00, 5'h00, 5'h18, 8'd3};
    vecs[21] = '{5'h10, 1'b1, 1'b0, 5'h08, 5'h00, 5'h00, 5'h18, 8'd3};
    vecs[22] = '{5'h10, 1'b1, 1'b0, 5'h10, 5'h10, 5'h08, 5'h00, 8'd3};
    vecs[23] = '{5'h10, 1'b1, 1'b0, 5'h10, 5'h00, 5'h00, 5'h00, 8'd3};

    rst        = 1'b1;
    raw_in     = 5'h00;
    enable     = 1'b1;
    glitch_clr = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("reset_state", 5'h00, 5'h00, 5'h00, 5'h00, 8'd0);
    rst = 1'b0;

    // Rise on ch3, glitch on ch0, dual glitch on ch1/2, coincident rise/fall.
    for (int i = 0; i < 24; i++) begin
      cyc(vecs[i].raw, vecs[i].en, vecs[i].clr);
      check($sformatf("vec%0d", i), vecs[i].ex, vecs[i].er, vecs[i].ef, vecs[i].ep, vecs[i].eg);
    end

    // Saturation: ch0 toggling every cycle produces a glitch every other edge.
    for (int i = 0; i < 300; i++) begin
      cyc(5'h11, 1'b1, 1'b0);
      cyc(5'h10, 1'b1, 1'b0);
    end
    for (int i = 0; i < 4; i++) cyc(5'h10, 1'b1, 1'b0);
    check("gcnt_saturated", 5'h10, 5'h00, 5'h00, 5'h00, 8'd255);

    // Clear coinciding with a glitch event on ch0.
    cyc(5'h11, 1'b1, 1'b0);
    cyc(5'h11, 1'b1, 1'b0);
    cyc(5'h10, 1'b1, 1'b0);
    cyc(5'h10, 1'b1, 1'b0);
    check("pend_before_clr", 5'h10, 5'h00, 5'h00, 5'h01, 8'd255);
    cyc(5'h10, 1'b1, 1'b1);
    check("clr_wins", 5'h10, 5'h00, 5'h00, 5'h00, 8'd0);
    cyc(5'h10, 1'b1, 1'b0);
    check("clr_holds", 5'h10, 5'h00, 5'h00, 5'h00, 8'd0);

    // Enable dropped after two PEND edges, restored five cycles later.
    for (int i = 0; i < 4; i++) cyc(5'h12, 1'b1, 1'b0);
    check("en_pend2", 5'h10, 5'h00, 5'h00, 5'h02, 8'd0);
    for (int i = 0; i < 5; i++) begin
      cyc(5'h12, 1'b0, 1'b0);
      check($sformatf("disabled%0d", i), 5'h10, 5'h00, 5'h00, 5'h00, 8'd0);
    end
    for (int i = 0; i < 3; i++) begin
      cyc(5'h12, 1'b1, 1'b0);
      check($sformatf("reen%0d", i + 1), 5'h10, 5'h00, 5'h00, 5'h02, 8'd0);
    end
    cyc(5'h12, 1'b1, 1'b0);
    check("reen4_update", 5'h12, 5'h02, 5'h00, 5'h00, 8'd0);
    cyc(5'h12, 1'b1, 1'b0);
    check("reen5_pulse_end", 5'h12, 5'h00, 5'h00, 5'h00, 8'd0);

    // Asynchronous reset in the middle of a ch0 PEND.
    for (int i = 0; i < 3; i++) cyc(5'h13, 1'b1, 1'b0);
    check("pre_rst_pend", 5'h12, 5'h00, 5'h00, 5'h01, 8'd0);
    rst = 1'b1;
    #2;
    check("async_rst", 5'h00, 5'h00, 5'h00, 5'h00, 8'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    cyc(5'h13, 1'b1, 1'b0);
    check("post_rst_no_fall", 5'h00, 5'h00, 5'h00, 5'h00, 8'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
